// File: rtl/upper_imm_if.sv
// Handshake bundle for the upper-immediate unit: instruction in, writeback out.
// The master side offers instructions and consumes results; the slave side is the unit.
interface upper_imm_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_result;
  logic        out_we;
  logic        out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_rd, out_result, out_we, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_rd, out_result, out_we, out_illegal
  );
endinterface

// File: rtl/upper_imm_unit.sv
// Two-stage LUI/AUIPC unit. S1 decodes and holds fields; S2 forms the upper
// immediate, adds the PC for AUIPC, and presents the writeback.
// Occupancy of the two stages is tracked by a four-state FSM.
module upper_imm_unit #(
  parameter bit AUIPC_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  upper_imm_if.slave  bus
);

  localparam logic [6:0] OPC_LUI   = 7'h37;
  localparam logic [6:0] OPC_AUIPC = 7'h17;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    S1_ONLY = 2'b01,
    S2_ONLY = 2'b10,
    FULL    = 2'b11
  } occ_t;

  typedef enum logic [1:0] {
    CLS_OTHER = 2'b00,
    CLS_LUI   = 2'b01,
    CLS_AUIPC = 2'b10
  } cls_t;

  occ_t        state;
  occ_t        state_next;

  logic        s1_valid;
  logic        s2_valid;
  logic        s1_next;
  logic        s2_next;

  logic        accept;
  logic        advance;
  logic        consume;

  cls_t        in_cls;

  cls_t        s1_cls;
  logic [19:0] s1_imm20;
  logic [4:0]  s1_rd;
  logic [31:0] s1_pc;

  cls_t        s2_cls;
  logic [19:0] s2_imm20;
  logic [4:0]  s2_rd;
  logic [31:0] s2_pc;

  logic [31:0] ext;
  logic [31:0] result;

  // Per-stage valid bits are views of the occupancy state.
  assign s1_valid = (state == S1_ONLY) || (state == FULL);
  assign s2_valid = (state == S2_ONLY) || (state == FULL);

  // Handshake events. A flush blocks acceptance; it does not need to gate
  // advance or consume because the next state is forced empty anyway.
  assign consume  = s2_valid && bus.out_ready;
  assign advance  = s1_valid && (!s2_valid || consume);
  assign bus.in_ready = !flush && (!s1_valid || advance);
  assign accept   = bus.in_valid && bus.in_ready;

  // Classify the incoming opcode; AUIPC only counts when the feature is enabled.
  // NOTE: every signal written in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    in_cls = CLS_OTHER;
    if (bus.in_instr[6:0] == OPC_LUI) begin
      in_cls = CLS_LUI;
    end else if (AUIPC_EN && (bus.in_instr[6:0] == OPC_AUIPC)) begin
      in_cls = CLS_AUIPC;
    end
  end

  // Occupancy state register; reset discards everything in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next occupancy from accept/advance/consume; flush empties both stages.
  always_comb begin
    s1_next    = accept  || (s1_valid && !advance);
    s2_next    = advance || (s2_valid && !consume);
    state_next = EMPTY;
    if (!flush) begin
      case ({s2_next, s1_next})
        2'b01:   state_next = S1_ONLY;
        2'b10:   state_next = S2_ONLY;
        2'b11:   state_next = FULL;
        default: state_next = EMPTY;
      endcase
    end
  end

  // S1 field capture on accept.
  // NOTE: datapath registers carry no reset; the valid bits qualify them, and
  // leaving them unreset keeps the reset tree on control state only.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_cls   <= in_cls;
      s1_imm20 <= bus.in_instr[31:12];
      s1_rd    <= bus.in_instr[11:7];
      s1_pc    <= bus.in_pc;
    end
  end

  // S2 load from S1 on advance; held unchanged while the result is stalled.
  always_ff @(posedge clk) begin
    if (advance) begin
      s2_cls   <= s1_cls;
      s2_imm20 <= s1_imm20;
      s2_rd    <= s1_rd;
      s2_pc    <= s1_pc;
    end
  end

  // Upper-aligned immediate: no sign handling, low twelve bits are zero.
  assign ext = {s2_imm20, 12'h000};

  // Execute: LUI passes the immediate, AUIPC adds the PC (carry dropped).
  always_comb begin
    result = 32'h0000_0000;
    case (s2_cls)
      CLS_LUI:   result = ext;
      CLS_AUIPC: result = s2_pc + ext;
      default:   result = 32'h0000_0000;
    endcase
  end

  // Outputs are forced to zero whenever S2 is empty, which also makes them
  // clear immediately under reset without resetting the datapath.
  assign bus.out_valid   = s2_valid;
  assign bus.out_rd      = s2_valid ? s2_rd  : 5'd0;
  assign bus.out_result  = s2_valid ? result : 32'h0000_0000;
  assign bus.out_we      = s2_valid && (s2_cls != CLS_OTHER) && (s2_rd != 5'd0);
  assign bus.out_illegal = s2_valid && (s2_cls == CLS_OTHER);

endmodule

// File: tb/tb_upper_imm_unit.sv
// Directed bench for upper_imm_unit: reset, LUI, AUIPC (enabled and
// disabled), illegal/x0, streaming, backpressure, flush and mid-stream reset.
module tb_upper_imm_unit;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  upper_imm_if bus ();
  upper_imm_if bus_n ();

  upper_imm_unit dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  upper_imm_unit #(.AUIPC_EN(1'b0)) dut_n (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus_n.slave)
  );

  function automatic logic [31:0] lui(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'h37};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction to both units for a single cycle, then wait until
  // it should be visible at the output (two edges after acceptance).
  task automatic issue_one(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_instr   = instr;
    bus.in_pc      = pc;
    bus.in_valid   = 1'b1;
    bus_n.in_instr = instr;
    bus_n.in_pc    = pc;
    bus_n.in_valid = 1'b1;
    tick();
    bus.in_valid   = 1'b0;
    bus_n.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;  bus.in_instr = 32'h0;  bus.in_pc = 32'h0;  bus.out_ready = 1'b1;
    bus_n.in_valid = 1'b0; bus_n.in_instr = 32'h0; bus_n.in_pc = 32'h0; bus_n.out_ready = 1'b1;
    #3;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_we !== 1'b0) begin bad++; $display("FAIL reset_out_we got=%b want=0", bus.out_we); end
    total++; if (bus.out_illegal !== 1'b0) begin bad++; $display("FAIL reset_out_illegal got=%b want=0", bus.out_illegal); end
    total++; if (bus.out_rd !== 5'd0) begin bad++; $display("FAIL reset_out_rd got=%0d want=0", bus.out_rd); end
    total++; if (bus.out_result !== 32'h0) begin bad++; $display("FAIL reset_out_result got=%h want=00000000", bus.out_result); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lui();
    bus.in_instr = 32'h123452B7;
    bus.in_pc    = 32'h0000_0100;
    bus.in_valid = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL lui_in_ready got=%b want=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL lui_latency1 got=%b want=0", bus.out_valid); end
    tick();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL lui_valid got=%b want=1", bus.out_valid); end
    total++; if (bus.out_result !== 32'h12345000) begin bad++; $display("FAIL lui_result got=%h want=12345000", bus.out_result); end
    total++; if (bus.out_rd !== 5'd5) begin bad++; $display("FAIL lui_rd got=%0d want=5", bus.out_rd); end
    total++; if (bus.out_we !== 1'b1) begin bad++; $display("FAIL lui_we got=%b want=1", bus.out_we); end
    total++; if (bus.out_illegal !== 1'b0) begin bad++; $display("FAIL lui_illegal got=%b want=0", bus.out_illegal); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL lui_retired got=%b want=0", bus.out_valid); end
    total++; if (bus.out_we !== 1'b0) begin bad++; $display("FAIL lui_we_idle got=%b want=0", bus.out_we); end
  endtask

  task automatic test_auipc();
    issue_one(32'h00001517, 32'hFFFFF000);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL auipc_wrap_valid got=%b want=1", bus.out_valid); end
    total++; if (bus.out_result !== 32'h0) begin bad++; $display("FAIL auipc_wrap_result got=%h want=00000000", bus.out_result); end
    total++; if (bus.out_rd !== 5'd10) begin bad++; $display("FAIL auipc_wrap_rd got=%0d want=10", bus.out_rd); end
    total++; if (bus.out_we !== 1'b1) begin bad++; $display("FAIL auipc_wrap_we got=%b want=1", bus.out_we); end
    total++; if (bus.out_illegal !== 1'b0) begin bad++; $display("FAIL auipc_wrap_illegal got=%b want=0", bus.out_illegal); end
    total++; if (bus_n.out_valid !== 1'b1) begin bad++; $display("FAIL auipc_off_valid got=%b want=1", bus_n.out_valid); end
    total++; if (bus_n.out_illegal !== 1'b1) begin bad++; $display("FAIL auipc_off_illegal got=%b want=1", bus_n.out_illegal); end
    total++; if (bus_n.out_we !== 1'b0) begin bad++; $display("FAIL auipc_off_we got=%b want=0", bus_n.out_we); end
    total++; if (bus_n.out_result !== 32'h0) begin bad++; $display("FAIL auipc_off_result got=%h want=00000000", bus_n.out_result); end
    total++; if (bus_n.out_rd !== 5'd10) begin bad++; $display("FAIL auipc_off_rd got=%0d want=10", bus_n.out_rd); end
    tick();
    issue_one(32'h12345097, 32'h0000_1000);
    total++; if (bus.out_result !== 32'h12346000) begin bad++; $display("FAIL auipc_add_result got=%h want=12346000", bus.out_result); end
    total++; if (bus.out_rd !== 5'd1) begin bad++; $display("FAIL auipc_add_rd got=%0d want=1", bus.out_rd); end
    total++; if (bus.out_we !== 1'b1) begin bad++; $display("FAIL auipc_add_we got=%b want=1", bus.out_we); end
    tick();
  endtask

  task automatic test_illegal_x0();
    issue_one(32'h00000033, 32'h0000_2000);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL illegal_valid got=%b want=1", bus.out_valid); end
    total++; if (bus.out_illegal !== 1'b1) begin bad++; $display("FAIL illegal_flag got=%b want=1", bus.out_illegal); end
    total++; if (bus.out_we !== 1'b0) begin bad++; $display("FAIL illegal_we got=%b want=0", bus.out_we); end
    total++; if (bus.out_result !== 32'h0) begin bad++; $display("FAIL illegal_result got=%h want=00000000", bus.out_result); end
    tick();
    issue_one(32'hABCDE037, 32'h0000_3000);
    total++; if (bus.out_result !== 32'hABCDE000) begin bad++; $display("FAIL x0_result got=%h want=abcde000", bus.out_result); end
    total++; if (bus.out_we !== 1'b0) begin bad++; $display("FAIL x0_we got=%b want=0", bus.out_we); end
    total++; if (bus.out_illegal !== 1'b0) begin bad++; $display("FAIL x0_illegal got=%b want=0", bus.out_illegal); end
    total++; if (bus.out_rd !== 5'd0) begin bad++; $display("FAIL x0_rd got=%0d want=0", bus.out_rd); end
    tick();
  endtask

  // Three LUIs on consecutive cycles: results appear on cycles 2..4, one per cycle.
  task automatic test_back_to_back();
    logic [31:0] want;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = (c < 3);
      bus.in_instr = lui(20'(32'hA0000 + c), 5'(3 + c));
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready c=%0d got=%b want=1", c, bus.in_ready); end
      if (c >= 2 && c < 5) begin
        want = {20'(32'hA0000 + c - 2), 12'h000};
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid c=%0d got=%b want=1", c, bus.out_valid); end
        total++; if (bus.out_result !== want) begin bad++; $display("FAIL b2b_result c=%0d got=%h want=%h", c, bus.out_result, want); end
        total++; if (bus.out_rd !== 5'(1 + c)) begin bad++; $display("FAIL b2b_rd c=%0d got=%0d want=%0d", c, bus.out_rd, 1 + c); end
      end else begin
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle c=%0d got=%b want=0", c, bus.out_valid); end
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  // Four LUIs offered back to back while the output stalls for six cycles.
  task automatic test_backpressure();
    int   idx = 0;
    logic acc;
    logic [31:0] want;
    logic exp_rdy [8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int   exp_out [11] = '{-1, -1, 0, 0, 0, 0, 0, 1, 2, 3, -1};
    for (int c = 0; c < 11; c++) begin
      bus.out_ready = (c >= 6);
      bus.in_valid  = (idx < 4);
      bus.in_instr  = lui(20'(32'h55000 + idx), 5'(8 + idx));
      #1;
      if (c < 8) begin
        total++; if (bus.in_ready !== exp_rdy[c]) begin bad++; $display("FAIL bp_in_ready c=%0d got=%b want=%b", c, bus.in_ready, exp_rdy[c]); end
      end
      if (exp_out[c] >= 0) begin
        want = {20'(32'h55000 + exp_out[c]), 12'h000};
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c=%0d got=%b want=1", c, bus.out_valid); end
        total++; if (bus.out_result !== want) begin bad++; $display("FAIL bp_result c=%0d got=%h want=%h", c, bus.out_result, want); end
        total++; if (bus.out_rd !== 5'(8 + exp_out[c])) begin bad++; $display("FAIL bp_rd c=%0d got=%0d want=%0d", c, bus.out_rd, 8 + exp_out[c]); end
      end else begin
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_idle c=%0d got=%b want=0", c, bus.out_valid); end
      end
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) idx++;
    end
    total++; if (idx != 4) begin bad++; $display("FAIL bp_accepted got=%0d want=4", idx); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = lui(20'h77777, 5'd7);
    tick();
    bus.in_instr  = lui(20'h88888, 5'd8);
    tick();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL flush_prefill got=%b want=1", bus.out_valid); end
    flush        = 1'b1;
    bus.in_instr = lui(20'h99999, 5'd9);
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", bus.in_ready); end
    tick();
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_cleared got=%b want=0", bus.out_valid); end
    total++; if (bus.out_we !== 1'b0) begin bad++; $display("FAIL flush_we got=%b want=0", bus.out_we); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready_after got=%b want=1", bus.in_ready); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_s1_empty got=%b want=0", bus.out_valid); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_accept got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = lui(20'h31000, 5'd3);
    tick();
    bus.in_instr  = lui(20'h32000, 5'd4);
    tick();
    bus.in_valid  = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_prefill got=%b want=1", bus.out_valid); end
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_result !== 32'h0) begin bad++; $display("FAIL rstmid_result got=%h want=00000000", bus.out_result); end
    total++; if (bus.out_rd !== 5'd0) begin bad++; $display("FAIL rstmid_rd got=%0d want=0", bus.out_rd); end
    total++; if (bus.out_we !== 1'b0) begin bad++; $display("FAIL rstmid_we got=%b want=0", bus.out_we); end
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = lui(20'h4AAAA, 5'd12);
    tick();
    bus.in_valid = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_lat1 got=%b want=0", bus.out_valid); end
    tick();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_lat2 got=%b want=1", bus.out_valid); end
    total++; if (bus.out_result !== 32'h4AAAA000) begin bad++; $display("FAIL rstmid_new_result got=%h want=4aaaa000", bus.out_result); end
    total++; if (bus.out_rd !== 5'd12) begin bad++; $display("FAIL rstmid_new_rd got=%0d want=12", bus.out_rd); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_drained got=%b want=0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_lui();
    test_auipc();
    test_illegal_x0();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
